// File: rtl/decode_nibble_alu_if.sv
// Request/result bundle between the control FSM (master) and the nibble-serial adder (slave).
interface decode_nibble_alu_if;
    logic        loop_perm_to_count;
    logic [2:0]  loop_nibbles_number;
    logic        word2_is_signed_and_negative;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] preinit_result;
    logic [31:0] result;
    logic        busy;
    logic [3:0]  ctrl;

    modport master (
        output loop_perm_to_count, loop_nibbles_number, word2_is_signed_and_negative,
        output word1, word2, preinit_result,
        input  result, busy, ctrl
    );

    modport slave (
        input  loop_perm_to_count, loop_nibbles_number, word2_is_signed_and_negative,
        input  word1, word2, preinit_result,
        output result, busy, ctrl
    );
endinterface

// File: rtl/decode_nibble_alu.sv
// RV32I instruction field decode plus a 4-bit-per-clock serial adder with early termination.
module decode_nibble_alu (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                i_instr,
    output logic [6:0]                 o_opcode,
    output logic [4:0]                 o_rd,
    output logic [4:0]                 o_rs1,
    output logic [4:0]                 o_rs2,
    output logic [2:0]                 o_funct3,
    output logic [11:0]                o_imm12,
    output logic [19:0]                o_imm20,
    output logic [23:0]                o_imm_jump,
    decode_nibble_alu_if.slave         bus
);
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Purely combinational decode
    assign o_opcode   = i_instr[6:0];
    assign o_rd       = i_instr[11:7];
    assign o_rs1      = i_instr[19:15];
    assign o_rs2      = i_instr[24:20];
    assign o_funct3   = i_instr[14:12];
    assign o_imm12    = (i_instr[6:0] == OPC_STORE) ? {i_instr[31:25], i_instr[11:7]}
                                                     : i_instr[31:20];
    assign o_imm20    = i_instr[31:12];
    assign o_imm_jump = {{3{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};

    logic [31:0] r_result;
    logic [2:0]  r_idx;
    logic        r_carry;
    logic        r_done;

    logic [4:0]  w_bit;
    logic [3:0]  w_nib1;
    logic [3:0]  w_nib2;
    logic [4:0]  w_sum;
    logic        w_final;
    logic [31:0] w_next_result;

    // Nibbles of word2 beyond the selected field come from the extension fill
    function automatic logic [3:0] word2_nibble(input logic [31:0] w2, input logic [2:0] idx,
                                                input logic [2:0] last, input logic neg);
        logic [3:0] nib;
        nib = w2[{idx, 2'b00} +: 4];
        return (idx <= last) ? nib : {4{neg}};
    endfunction

    always_comb begin
        w_bit   = {r_idx, 2'b00};
        w_nib1  = bus.word1[w_bit +: 4];
        w_nib2  = word2_nibble(bus.word2, r_idx, bus.loop_nibbles_number,
                               bus.word2_is_signed_and_negative);
        w_sum   = {1'b0, w_nib1} + {1'b0, w_nib2} + {4'b0000, r_carry};
        w_final = (r_idx == 3'd7) ||
                  ((r_idx >= bus.loop_nibbles_number) && !bus.word2_is_signed_and_negative &&
                   !w_sum[4]);
        w_next_result = r_result;
        w_next_result[w_bit +: 4] = w_sum[3:0];
        // With no pending carry and zero fill, the remaining sum nibbles equal word1's
        if (w_final) begin
            for (int j = 0; j < 8; j++) begin
                if (j > int'(r_idx)) begin
                    w_next_result[4*j +: 4] = bus.word1[4*j +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else if (!bus.loop_perm_to_count) begin
            r_result <= bus.preinit_result;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else if (!r_done) begin
            r_result <= w_next_result;
            r_carry  <= w_sum[4];
            r_idx    <= w_final ? 3'd0 : r_idx + 3'd1;
            r_done   <= w_final;
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = bus.loop_perm_to_count & ~r_done;
    assign bus.ctrl   = {r_carry, r_idx};
endmodule

// File: tb/tb_decode_nibble_alu.sv
// Randomized self-checking bench: decode fields and serial sums against an arithmetic model.
module tb_decode_nibble_alu;
    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [23:0] imm_jump;

    int n_tests;
    int n_fail;

    decode_nibble_alu_if bus ();

    decode_nibble_alu dut (
        .clk        (clk),
        .rst        (rst),
        .i_instr    (instr),
        .o_opcode   (opcode),
        .o_rd       (rd),
        .o_rs1      (rs1),
        .o_rs2      (rs2),
        .o_funct3   (funct3),
        .o_imm12    (imm12),
        .o_imm20    (imm20),
        .o_imm_jump (imm_jump),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Extended word2 operand from the field/sign rules, as a 32-bit value
    function automatic logic [31:0] model_ext(input logic [31:0] w2, input int n, input logic neg);
        logic [63:0] mask;
        mask = (64'd1 << (4*n + 4)) - 64'd1;
        return neg ? ((w2 & mask[31:0]) | ~mask[31:0]) : (w2 & mask[31:0]);
    endfunction

    // Carry out of the low (i+1) nibbles of w1 + ext
    function automatic logic model_carry(input logic [31:0] w1, input logic [31:0] ext, input int i);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << (4*i + 4)) - 64'd1;
        s = ({32'd0, w1} & mask) + ({32'd0, ext} & mask);
        return s[4*i + 4];
    endfunction

    function automatic int model_k(input logic [31:0] w1, input logic [31:0] ext, input int n,
                                   input logic neg);
        if (neg) return 8;
        for (int i = n; i < 8; i++) begin
            if (!model_carry(w1, ext, i)) return i + 1;
        end
        return 8;
    endfunction

    task automatic run_add(input logic [31:0] w1, input logic [31:0] w2, input int n,
                           input logic neg, input logic [31:0] pre);
        logic [31:0] ext;
        logic [31:0] exp_sum;
        int          k;
        int          cyc;
        logic        cfin;
        ext     = model_ext(w2, n, neg);
        exp_sum = w1 + ext;
        k       = model_k(w1, ext, n, neg);
        cfin    = (k == 8) ? model_carry(w1, ext, 7) : 1'b0;

        bus.loop_perm_to_count           = 1'b0;
        bus.word1                        = w1;
        bus.word2                        = w2;
        bus.loop_nibbles_number          = 3'(n);
        bus.word2_is_signed_and_negative = neg;
        bus.preinit_result               = pre;
        tick();
        chk("preload", bus.result, pre);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_ctrl", {28'd0, bus.ctrl}, 32'd0);

        bus.loop_perm_to_count = 1'b1;
        #1;
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("cycles", cyc, k);
        chk("sum", bus.result, exp_sum);
        chk("ctrl_done", {28'd0, bus.ctrl}, {28'd0, cfin, 3'b000});
        tick();
        chk("hold", bus.result, exp_sum);
        chk("hold_busy", {31'd0, bus.busy}, 32'd0);
        bus.loop_perm_to_count = 1'b0;
        tick();
    endtask

    task automatic dec_rand(input logic [31:0] ins);
        logic [23:0] j;
        logic [11:0] i12;
        instr = ins;
        #1;
        j = {4'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        if (ins[31]) j = j | 24'hE00000;
        i12 = (ins[6:0] == 7'b0100011) ? 12'((ins >> 20) & 32'hFE0) | 12'((ins >> 7) & 32'h1F)
                                       : 12'(ins >> 20);
        chk("r_opcode", {25'd0, opcode}, ins & 32'h7F);
        chk("r_rd", {27'd0, rd}, (ins >> 7) & 32'h1F);
        chk("r_rs1", {27'd0, rs1}, (ins >> 15) & 32'h1F);
        chk("r_rs2", {27'd0, rs2}, (ins >> 20) & 32'h1F);
        chk("r_funct3", {29'd0, funct3}, (ins >> 12) & 32'h7);
        chk("r_imm12", {20'd0, imm12}, {20'd0, i12});
        chk("r_imm20", {12'd0, imm20}, ins >> 12);
        chk("r_imm_jump", {8'd0, imm_jump}, {8'd0, j});
    endtask

    initial begin
        logic [31:0] w1, w2, pre, ins;
        int          n;
        logic        neg;
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        instr = 32'd0;
        bus.loop_perm_to_count           = 1'b0;
        bus.loop_nibbles_number          = 3'd0;
        bus.word2_is_signed_and_negative = 1'b0;
        bus.word1                        = 32'd0;
        bus.word2                        = 32'd0;
        bus.preinit_result               = 32'hDEAD_BEEF;
        tick();
        chk("rst_result", bus.result, 32'd0);
        chk("rst_ctrl", {28'd0, bus.ctrl}, 32'd0);
        chk("rst_busy0", {31'd0, bus.busy}, 32'd0);
        bus.loop_perm_to_count = 1'b1;
        #1;
        chk("rst_busy1", {31'd0, bus.busy}, 32'd1);
        bus.loop_perm_to_count = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        instr = 32'h07B0_0293;
        #1;
        chk("addi_opcode", {25'd0, opcode}, 32'b0010011);
        chk("addi_rd", {27'd0, rd}, 32'd5);
        chk("addi_rs1", {27'd0, rs1}, 32'd0);
        chk("addi_funct3", {29'd0, funct3}, 32'd0);
        chk("addi_imm12", {20'd0, imm12}, 32'h07B);
        instr = 32'hFE72_AF23;
        #1;
        chk("sw_opcode", {25'd0, opcode}, 32'b0100011);
        chk("sw_rs1", {27'd0, rs1}, 32'd5);
        chk("sw_rs2", {27'd0, rs2}, 32'd7);
        chk("sw_funct3", {29'd0, funct3}, 32'b010);
        chk("sw_imm12", {20'd0, imm12}, 32'hFFE);
        instr = 32'h000F_0537;
        #1;
        chk("lui_imm20", {12'd0, imm20}, 32'h000F0);
        chk("lui_rd", {27'd0, rd}, 32'd10);
        instr = 32'hFFDF_F06F;
        #1;
        chk("jal_imm_jump", {8'd0, imm_jump}, 32'h00FF_FFFC);
        for (int t = 0; t < 20; t++) begin
            ins = $urandom;
            if (t % 3 == 0) ins = {ins[31:7], 7'b0100011};
            dec_rand(ins);
        end

        run_add(32'h0000_00FF, 32'd4, 0, 1'b0, 32'h0000_00FF);
        run_add(32'd0, 32'h800, 2, 1'b1, 32'd0);
        run_add(32'd123, 32'hFFE, 2, 1'b1, 32'd0);
        run_add(32'd123, 32'd5, 2, 1'b0, 32'd0);
        run_add(32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'h1234_5678);
        run_add(32'h8000_0000, 32'h8000_0000, 7, 1'b0, 32'd0);

        // Reset pulse mid-count
        bus.word1 = 32'h0FFF_FFFF; bus.word2 = 32'd1;
        bus.loop_nibbles_number = 3'd0; bus.word2_is_signed_and_negative = 1'b0;
        bus.preinit_result = 32'h5555_AAAA;
        tick();
        bus.loop_perm_to_count = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_result", bus.result, 32'd0);
        chk("rst_mid_ctrl", {28'd0, bus.ctrl}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        rst = 1'b0;
        bus.loop_perm_to_count = 1'b0;
        tick();

        // Abort by dropping the request
        bus.loop_perm_to_count = 1'b1;
        tick();
        tick();
        bus.loop_perm_to_count = 1'b0;
        tick();
        chk("abort_result", bus.result, 32'h5555_AAAA);
        chk("abort_ctrl", {28'd0, bus.ctrl}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        run_add(32'h0FFF_FFFF, 32'd1, 0, 1'b0, 32'h5555_AAAA);

        for (int t = 0; t < 30; t++) begin
            w1  = $urandom;
            w2  = $urandom;
            pre = $urandom;
            n   = int'($urandom_range(7, 0));
            neg = 1'($urandom_range(1, 0));
            if (neg) w2 = w2 | (32'd8 << (4*n));
            if (t % 4 == 0) w1 = w1 | 32'h0FFF_FFF0;
            run_add(w1, w2, n, neg, pre);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
